fetch_stub_icache: RTL

Parametrised, table-driven instruction-memory model for core bring-up. It replaces the fixed-table, zero-latency fetch stub with a programmable lookup table, a request/response handshake, configurable latency, multi-instruction fetch bundles, and flush support. It sits between the core's fetch unit and the (absent) real I-cache in simulation and FPGA bring-up builds.

---
 rtl/fetch_stub_icache.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_stub_icache.sv
// rtl/fetch_stub_icache.sv - table-driven instruction-memory model with latency, bundles and flush
module fetch_stub_icache #(
    parameter int                XLEN        = 32,
    parameter int                ADDR_WIDTH  = 32,
    parameter int                DEPTH       = 32,
    parameter int                FETCH_WIDTH = 2,
    parameter int                LATENCY     = 2,
    parameter logic [XLEN-1:0]   MISS_INSN   = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [XLEN*FETCH_WIDTH-1:0]   resp_insn,
    output logic [FETCH_WIDTH-1:0]        resp_hit,
    output logic                          resp_misalign,
    input  logic                          flush,
    input  logic                          load_valid,
    input  logic [$clog2(DEPTH)-1:0]      load_index,
    input  logic [ADDR_WIDTH-1:0]         load_addr,
    input  logic [XLEN-1:0]               load_data
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [XLEN*FETCH_WIDTH-1:0]    pend_insn_q, pend_insn_d;
    logic [FETCH_WIDTH-1:0]         pend_hit_q, pend_hit_d;
    logic                           pend_misalign_q, pend_misalign_d;

    logic [DEPTH-1:0]               valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]          tag_q [DEPTH];
    logic [ADDR_WIDTH-1:0]          tag_d [DEPTH];
    logic [XLEN-1:0]                data_q [DEPTH];
    logic [XLEN-1:0]                data_d [DEPTH];

    logic [XLEN*FETCH_WIDTH-1:0]    look_insn;
    logic [FETCH_WIDTH-1:0]         look_hit;
    logic [ADDR_WIDTH-1:0]          word_addr;
    logic                           misalign;

    // Indices beyond DEPTH are only reachable when DEPTH is not a power of two.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (load_valid && (32'(load_index) < DEPTH)) begin
            valid_d[load_index] = 1'b1;
            tag_d[load_index]   = load_addr;
            data_d[load_index]  = load_data;
        end
    end

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        look_insn = '0;
        look_hit  = '0;
        word_addr = '0;
        misalign  = (req_addr[1:0] != 2'b00);
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            word_addr = req_addr + ADDR_WIDTH'(4 * k);
            look_insn[k*XLEN +: XLEN] = MISS_INSN;
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (valid_q[j] && (tag_q[j] == word_addr)) begin
                    look_insn[k*XLEN +: XLEN] = data_q[j];
                    look_hit[k]               = 1'b1;
                end
            end
        end
        if (misalign) begin
            look_insn = {FETCH_WIDTH{MISS_INSN}};
            look_hit  = '0;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pend_insn_d     = pend_insn_q;
        pend_hit_d      = pend_hit_q;
        pend_misalign_d = pend_misalign_q;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    pend_insn_d     = look_insn;
                    pend_hit_d      = look_hit;
                    pend_misalign_d = misalign;
                    cnt_d           = CNT_LOAD;
                    state_d         = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response fields read as zero outside RESP, so they only move on entry and exit.
    assign resp_insn     = (state_q == S_RESP) ? pend_insn_q : '0;
    assign resp_hit      = (state_q == S_RESP) ? pend_hit_q : '0;
    assign resp_misalign = (state_q == S_RESP) ? pend_misalign_q : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            pend_insn_q     <= '0;
            pend_hit_q      <= '0;
            pend_misalign_q <= 1'b0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pend_insn_q     <= pend_insn_d;
            pend_hit_q      <= pend_hit_d;
            pend_misalign_q <= pend_misalign_d;
            valid_q         <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule
